// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a fetch port (I) and a data port (D).
// Define MEM_ARB_FAIR_EN to add a burst counter that stops the data port starving fetches.
module mem_arbiter #(
    parameter int MAX_D_BURST = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iReq,
    input  logic [15:0] iAddr,
    output logic [15:0] iData,
    output logic        iStall,
    output logic        iDone,
    input  logic        dRd,
    input  logic        dWr,
    input  logic [15:0] dAddr,
    input  logic [15:0] dWriteData,
    output logic [15:0] dReadData,
    output logic        dStall,
    output logic        dDone,
    output logic        memRd,
    output logic        memWr,
    output logic [15:0] memAddr,
    output logic [15:0] memDataIn,
    input  logic [15:0] memDataOut,
    input  logic        memStall,
    input  logic        memDone,
    input  logic        memErr,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arbState;

    arbState     state, nextState;
    logic        owner, opWr, opIll;
    logic [15:0] addrLat, dataLat;
    logic        dPend, grant, grantD, done;

    // The burst counter is two bits wide, so limits above 3 could never be reached.
    if (MAX_D_BURST < 1 || MAX_D_BURST > 3) begin : gBadBurst
        $error("MAX_D_BURST must be 1..3");
    end

    assign dPend = dRd || dWr;
    assign grant = state == IDLE && (iReq || dPend);

`ifdef MEM_ARB_FAIR_EN
    logic [1:0] burstCnt;

    assign grantD = dPend && !(iReq && burstCnt == 2'(MAX_D_BURST));

    // Count data grants that overtook a waiting fetch; any fetch grant restarts the count.
    always_ff @(posedge clk) begin
        if (!rst)
            burstCnt <= '0;
        else if (grant)
            burstCnt <= grantD ? burstCnt + {1'b0, iReq} : '0;
    end
`else
    assign grantD = dPend;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Capture the winner's request at grant so later requester changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner   <= 1'b0;
            opWr    <= 1'b0;
            opIll   <= 1'b0;
            addrLat <= '0;
            dataLat <= '0;
        end else if (grant) begin
            owner   <= grantD;
            opWr    <= grantD && dWr;
            opIll   <= grantD && dRd && dWr;
            addrLat <= grantD ? dAddr : iAddr;
            dataLat <= grantD ? dWriteData : '0;
        end
    end

    // Next state and memory-side outputs; everything is forced low while in reset.
    always_comb begin
        nextState = state;
        done      = 1'b0;
        err       = 1'b0;
        memRd     = 1'b0;
        memWr     = 1'b0;
        memAddr   = '0;
        memDataIn = '0;
        case (state)
            IDLE: nextState = grant ? ISSUE : IDLE;
            ISSUE: begin
                if (opIll) begin
                    done      = 1'b1;
                    err       = 1'b1;
                    nextState = IDLE;
                end else begin
                    memRd     = !opWr;
                    memWr     = opWr;
                    memAddr   = addrLat;
                    memDataIn = dataLat;
                    done      = memDone;
                    err       = memDone && memErr;
                    nextState = memDone ? IDLE : (memStall ? ISSUE : WAIT);
                end
            end
            WAIT: begin
                done      = memDone;
                err       = memDone && memErr;
                nextState = memDone ? IDLE : WAIT;
            end
            default: nextState = IDLE;
        endcase
        if (!rst) begin
            done      = 1'b0;
            err       = 1'b0;
            memRd     = 1'b0;
            memWr     = 1'b0;
            memAddr   = '0;
            memDataIn = '0;
        end
    end

    assign iDone     = done && !owner;
    assign dDone     = done && owner;
    assign iData     = iDone ? memDataOut : '0;
    assign dReadData = (dDone && !opIll) ? memDataOut : '0;
    assign iStall    = rst && iReq && !iDone;
    assign dStall    = rst && dPend && !dDone;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic checked against a transaction-level model.
module tb_mem_arbiter;
`ifdef MEM_ARB_FAIR_EN
    localparam bit Fair = 1'b1;
`else
    localparam bit Fair = 1'b0;
`endif
    localparam int MaxD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iReq = 1'b0, dRd = 1'b0, dWr = 1'b0;
    logic [15:0] iAddr = '0, dAddr = '0, dWriteData = '0, memDataOut = '0;
    logic        memStall = 1'b0, memDone = 1'b0, memErr = 1'b0;
    logic [15:0] iData, dReadData, memAddr, memDataIn;
    logic        iStall, iDone, dStall, dDone, memRd, memWr, err;

    int nChecks = 0;
    int nFail = 0;

    mem_arbiter #(.MAX_D_BURST(MaxD)) dut (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iData(iData), .iStall(iStall), .iDone(iDone),
        .dRd(dRd), .dWr(dWr), .dAddr(dAddr), .dWriteData(dWriteData),
        .dReadData(dReadData), .dStall(dStall), .dDone(dDone),
        .memRd(memRd), .memWr(memWr), .memAddr(memAddr), .memDataIn(memDataIn),
        .memDataOut(memDataOut), .memStall(memStall), .memDone(memDone),
        .memErr(memErr), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction model: one outstanding transfer, who won it, and whether memory took it.
    bit          mBusy = 0, mOwnD = 0, mWr = 0, mIll = 0, mAcc = 0;
    logic [15:0] mAddr = '0, mData = '0;
    int          mCnt = 0;
    bit          expIDone = 0, expDDone = 0;

    always @(negedge clk) begin
        bit eDone, eI, eD, eRd, eWr, goD;
        eDone = rst && mBusy && (mIll || memDone);
        eI    = eDone && !mOwnD;
        eD    = eDone && mOwnD;
        eRd   = rst && mBusy && !mAcc && !mIll && !mWr;
        eWr   = rst && mBusy && !mAcc && !mIll && mWr;
        chk("iDone", 16'(iDone), 16'(eI));
        chk("dDone", 16'(dDone), 16'(eD));
        chk("err", 16'(err), 16'(eDone && (mIll || memErr)));
        chk("iData", iData, eI ? memDataOut : 16'h0);
        chk("dReadData", dReadData, (eD && !mIll) ? memDataOut : 16'h0);
        chk("iStall", 16'(iStall), 16'(rst && iReq && !eI));
        chk("dStall", 16'(dStall), 16'(rst && (dRd || dWr) && !eD));
        chk("memRd", 16'(memRd), 16'(eRd));
        chk("memWr", 16'(memWr), 16'(eWr));
        if (eRd || eWr) chk("memAddr", memAddr, mAddr);
        if (eWr) chk("memDataIn", memDataIn, mData);
        expIDone = eI;
        expDDone = eD;
        if (!rst) begin
            mBusy = 0;
            mCnt  = 0;
        end else if (!mBusy) begin
            if (iReq || dRd || dWr) begin
                goD   = (dRd || dWr) && !(Fair && iReq && mCnt == MaxD);
                mCnt  = (Fair && goD) ? mCnt + int'(iReq) : 0;
                mBusy = 1;
                mAcc  = 0;
                mOwnD = goD;
                mWr   = goD && dWr;
                mIll  = goD && dRd && dWr;
                mAddr = goD ? dAddr : iAddr;
                mData = goD ? dWriteData : 16'h0;
            end
        end else if (mIll || memDone) begin
            mBusy = 0;
        end else if (!memStall) begin
            mAcc = 1;
        end
    end

    initial begin
        int iCnt, dCnt, r;
        iReq = 1'b1;
        dWr  = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_iStall", 16'(iStall), 16'h0);
        chk("rst_dStall", 16'(dStall), 16'h0);
        chk("rst_memWr", 16'(memWr), 16'h0);
        tick();
        rst = 1'b1;
        iReq = 1'b0;
        dWr = 1'b0;
        tick();
        iReq = 1'b1;
        iAddr = 16'h0010;
        @(negedge clk);
        chk("f_grant_iStall", 16'(iStall), 16'h1);
        chk("f_grant_memRd", 16'(memRd), 16'h0);
        tick();
        @(negedge clk);
        chk("f_issue_memRd", 16'(memRd), 16'h1);
        chk("f_issue_memAddr", memAddr, 16'h0010);
        tick();
        @(negedge clk);
        chk("f_wait_memRd", 16'(memRd), 16'h0);
        chk("f_wait_iStall", 16'(iStall), 16'h1);
        tick();
        memDone = 1'b1;
        memDataOut = 16'hABCD;
        @(negedge clk);
        chk("f_done_iDone", 16'(iDone), 16'h1);
        chk("f_done_iData", iData, 16'hABCD);
        chk("f_done_iStall", 16'(iStall), 16'h0);
        tick();
        memDone = 1'b0;
        iAddr = 16'h0040;
        dWr = 1'b1;
        dAddr = 16'h0200;
        dWriteData = 16'h1234;
        @(negedge clk);
        chk("c_idle_memWr", 16'(memWr), 16'h0);
        tick();
        memDone = 1'b1;
        @(negedge clk);
        chk("c_memWr", 16'(memWr), 16'h1);
        chk("c_memRd", 16'(memRd), 16'h0);
        chk("c_memAddr", memAddr, 16'h0200);
        chk("c_memDataIn", memDataIn, 16'h1234);
        chk("c_dDone", 16'(dDone), 16'h1);
        chk("c_iDone", 16'(iDone), 16'h0);
        tick();
        dWr = 1'b0;
        memDone = 1'b0;
        @(negedge clk);
        chk("c_idle2_memRd", 16'(memRd), 16'h0);
        tick();
        memDone = 1'b1;
        @(negedge clk);
        chk("c_f_memRd", 16'(memRd), 16'h1);
        chk("c_f_memAddr", memAddr, 16'h0040);
        chk("c_f_iDone", 16'(iDone), 16'h1);
        tick();
        iReq = 1'b0;
        memDone = 1'b0;
        dRd = 1'b1;
        dAddr = 16'h0300;
        tick();
        memStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s_memRd", 16'(memRd), 16'h1);
            chk("s_memAddr", memAddr, 16'h0300);
            tick();
        end
        memStall = 1'b0;
        @(negedge clk);
        chk("s_accept_memRd", 16'(memRd), 16'h1);
        tick();
        memDone = 1'b1;
        memDataOut = 16'h5555;
        @(negedge clk);
        chk("s_done_memRd", 16'(memRd), 16'h0);
        chk("s_done_dDone", 16'(dDone), 16'h1);
        chk("s_done_dReadData", dReadData, 16'h5555);
        chk("s_done_iData", iData, 16'h0);
        tick();
        dRd = 1'b0;
        memDone = 1'b0;
        iReq = 1'b1;
        iAddr = 16'h0080;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("r_iStall", 16'(iStall), 16'h0);
        tick();
        rst = 1'b1;
        iReq = 1'b0;
        memDone = 1'b1;
        @(negedge clk);
        chk("r_iDone", 16'(iDone), 16'h0);
        chk("r_memRd", 16'(memRd), 16'h0);
        tick();
        memDone = 1'b0;
        dRd = 1'b1;
        dWr = 1'b1;
        dAddr = 16'h0400;
        @(negedge clk);
        chk("x_idle_err", 16'(err), 16'h0);
        tick();
        @(negedge clk);
        chk("x_err", 16'(err), 16'h1);
        chk("x_dDone", 16'(dDone), 16'h1);
        chk("x_memRd", 16'(memRd), 16'h0);
        chk("x_memWr", 16'(memWr), 16'h0);
        tick();
        dWr = 1'b0;
        iReq = 1'b1;
        iAddr = 16'h0100;
        dAddr = 16'h0500;
        memDone = 1'b1;
        iCnt = 0;
        dCnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iCnt += int'(iDone);
            dCnt += int'(dDone);
            tick();
        end
        chk("fair_iDones", 16'(iCnt), Fair ? 16'd1 : 16'd0);
        chk("fair_dDones", 16'(dCnt), Fair ? 16'd4 : 16'd5);
        iReq = 1'b0;
        dRd = 1'b0;
        memDone = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst = ($urandom % 64) != 0;
            if (expIDone || !iReq) begin
                iReq = ($urandom % 3) == 0;
                iAddr = 16'($urandom);
            end
            if (expDDone || !(dRd || dWr)) begin
                r = int'($urandom % 16);
                dRd = (r >= 6 && r <= 10) || r == 15;
                dWr = r >= 11;
                dAddr = 16'($urandom);
                dWriteData = 16'($urandom);
            end
            memStall = ($urandom % 3) == 0;
            memDone = ($urandom % 3) == 0;
            memErr = ($urandom % 4) == 0;
            memDataOut = 16'($urandom);
        end
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
